// File: rtl/timer_ctrl.sv
// Sequencing controller for the 8-bit timer counter: decodes TCR fields, runs the
// prescaler and produces the counter/last-value pair seen by the overflow checker.
module timer_ctrl #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 tmrctl_clk,
    input  logic                 tmrctl_reset,
    input  logic                 tmrctl_tcr_en,
    input  logic                 tmrctl_tcr_load,
    input  logic                 tmrctl_tcr_up_down,
    input  logic [1:0]           tmrctl_tcr_cks,
    input  logic [CNT_WIDTH-1:0] tmrctl_tdr,
    output logic [CNT_WIDTH-1:0] tmrctl_counter_value,
    output logic [CNT_WIDTH-1:0] tmrctl_counter_last_value,
    output logic                 tmrctl_tick,
    output logic [1:0]           tmrctl_state
);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_LOAD = 2'b10;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]           state_q, state_d;
    logic [3:0]           pre_cnt_q, pre_cnt_d;
    logic [1:0]           cks_q;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] last_q, last_d;
    logic                 tick_q, tick_d;

    logic [3:0]           pre_term;
    logic                 cks_changed;
    logic                 pre_hit;

    // Terminal count is 2^(cks+1)-1, giving divide-by 2/4/8/16.
    always_comb begin
        pre_term = 4'd1;
        case (tmrctl_tcr_cks)
            2'd0: pre_term = 4'd1;
            2'd1: pre_term = 4'd3;
            2'd2: pre_term = 4'd7;
            2'd3: pre_term = 4'd15;
        endcase
    end

    // A clock-select change only restarts the prescale while already running;
    // on RUN entry the prescaler is zero anyway and must start counting at once.
    assign cks_changed = (state_q == ST_RUN) && (tmrctl_tcr_cks != cks_q);
    assign pre_hit     = (pre_cnt_q >= pre_term) && !cks_changed;

    // The action taken at an edge follows the mode selected by the inputs at that
    // edge, so a single-cycle load pulse is applied immediately.
    always_comb begin
        if (tmrctl_tcr_load) begin
            state_d = ST_LOAD;
        end else if (tmrctl_tcr_en) begin
            state_d = ST_RUN;
        end else begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        pre_cnt_d = 4'd0;
        cnt_d     = cnt_q;
        last_d    = cnt_q;
        tick_d    = 1'b0;
        case (state_d)
            ST_LOAD: begin
                // last tracks the loaded value so the checker never sees a false wrap
                cnt_d  = tmrctl_tdr;
                last_d = tmrctl_tdr;
            end
            ST_RUN: begin
                if (cks_changed) begin
                    pre_cnt_d = 4'd0;
                end else if (pre_hit) begin
                    pre_cnt_d = 4'd0;
                    tick_d    = 1'b1;
                    if (tmrctl_tcr_up_down) begin
                        cnt_d = cnt_q - CNT_ONE;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    pre_cnt_d = pre_cnt_q + 4'd1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge tmrctl_clk) begin
        if (tmrctl_reset) begin
            state_q   <= ST_IDLE;
            pre_cnt_q <= 4'd0;
            cks_q     <= 2'd0;
            cnt_q     <= '0;
            last_q    <= '0;
            tick_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_cnt_q <= pre_cnt_d;
            cks_q     <= tmrctl_tcr_cks;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            tick_q    <= tick_d;
        end
    end

    assign tmrctl_counter_value      = cnt_q;
    assign tmrctl_counter_last_value = last_q;
    assign tmrctl_tick               = tick_q;
    assign tmrctl_state              = state_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl: a vector table for the short sequences and
// hand-written loops for the long prescale, halt/resume and clock-select cases.
module tb_timer_ctrl;

    logic       clk;
    logic       rst;
    logic       en;
    logic       load;
    logic       ud;
    logic [1:0] cks;
    logic [7:0] tdr;
    logic [7:0] val;
    logic [7:0] last;
    logic       tick;
    logic [1:0] state;

    int n_vec;
    int miscompares;

    typedef struct {
        logic       rst;
        logic       en;
        logic       load;
        logic       ud;
        logic [1:0] cks;
        logic [7:0] tdr;
        logic [7:0] e_val;
        logic [7:0] e_last;
        logic       e_tick;
        logic [1:0] e_state;
        string      name;
    } vec_t;

    vec_t tbl[$];

    timer_ctrl #(.CNT_WIDTH(8)) dut (
        .tmrctl_clk               (clk),
        .tmrctl_reset             (rst),
        .tmrctl_tcr_en            (en),
        .tmrctl_tcr_load          (load),
        .tmrctl_tcr_up_down       (ud),
        .tmrctl_tcr_cks           (cks),
        .tmrctl_tdr               (tdr),
        .tmrctl_counter_value     (val),
        .tmrctl_counter_last_value(last),
        .tmrctl_tick              (tick),
        .tmrctl_state             (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input string name, input logic r, input logic e, input logic l,
                       input logic u, input logic [1:0] c, input logic [7:0] t,
                       input logic [7:0] ev, input logic [7:0] el, input logic et,
                       input logic [1:0] es);
        vec_t v;
        v.name = name; v.rst = r; v.en = e; v.load = l; v.ud = u; v.cks = c; v.tdr = t;
        v.e_val = ev; v.e_last = el; v.e_tick = et; v.e_state = es;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic r, input logic e, input logic l, input logic u,
                         input logic [1:0] c, input logic [7:0] t);
        rst = r; en = e; load = l; ud = u; cks = c; tdr = t;
    endtask

    // Advance one edge, then compare outputs 1 time unit later.
    task automatic step_check(input string name, input logic [7:0] ev, input logic [7:0] el,
                              input logic et, input logic [1:0] es);
        @(posedge clk);
        #1;
        n_vec++;
        if (val !== ev || last !== el || tick !== et || state !== es) begin
            miscompares++;
            $display("FAIL %s: got value=%h last=%h tick=%b state=%b, want value=%h last=%h tick=%b state=%b",
                     name, val, last, tick, state, ev, el, et, es);
        end
    endtask

    initial begin
        drive(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'h55);
        n_vec = 0;
        miscompares = 0;

        //   name          rst en ld ud cks tdr      val    last   tk state
        add("reset0",      1, 1, 0, 0, 0, 8'h55,  8'h00, 8'h00, 0, 2'b00);
        add("reset1",      1, 1, 0, 0, 0, 8'h55,  8'h00, 8'h00, 0, 2'b00);
        add("reset2",      1, 1, 0, 0, 0, 8'h55,  8'h00, 8'h00, 0, 2'b00);
        add("rel_e1",      0, 1, 0, 0, 0, 8'h55,  8'h00, 8'h00, 0, 2'b01);
        add("rel_step",    0, 1, 0, 0, 0, 8'h55,  8'h01, 8'h00, 1, 2'b01);
        add("ud_e1",       0, 1, 0, 1, 0, 8'h55,  8'h01, 8'h01, 0, 2'b01);
        add("ud_step",     0, 1, 0, 1, 0, 8'h55,  8'h00, 8'h01, 1, 2'b01);
        add("load_fe",     0, 0, 1, 0, 0, 8'hFE,  8'hFE, 8'hFE, 0, 2'b10);
        add("idle_fe",     0, 0, 0, 0, 0, 8'hFE,  8'hFE, 8'hFE, 0, 2'b00);
        add("up_e1",       0, 1, 0, 0, 0, 8'hFE,  8'hFE, 8'hFE, 0, 2'b01);
        add("up_ff",       0, 1, 0, 0, 0, 8'hFE,  8'hFF, 8'hFE, 1, 2'b01);
        add("up_e3",       0, 1, 0, 0, 0, 8'hFE,  8'hFF, 8'hFF, 0, 2'b01);
        add("up_wrap",     0, 1, 0, 0, 0, 8'hFE,  8'h00, 8'hFF, 1, 2'b01);
        add("up_e5",       0, 1, 0, 0, 0, 8'hFE,  8'h00, 8'h00, 0, 2'b01);
        add("up_01",       0, 1, 0, 0, 0, 8'hFE,  8'h01, 8'h00, 1, 2'b01);
        add("up_halt",     0, 0, 0, 0, 0, 8'hFE,  8'h01, 8'h01, 0, 2'b00);
        add("load_7f",     0, 0, 1, 0, 0, 8'h7F,  8'h7F, 8'h7F, 0, 2'b10);
        add("run7f_e1",    0, 1, 0, 0, 0, 8'h7F,  8'h7F, 8'h7F, 0, 2'b01);
        add("run_80",      0, 1, 0, 0, 0, 8'h7F,  8'h80, 8'h7F, 1, 2'b01);
        add("load_en",     0, 1, 1, 0, 0, 8'hFF,  8'hFF, 8'hFF, 0, 2'b10);
        add("resume_e1",   0, 1, 0, 0, 0, 8'hFF,  8'hFF, 8'hFF, 0, 2'b01);
        add("resume_wrap", 0, 1, 0, 0, 0, 8'hFF,  8'h00, 8'hFF, 1, 2'b01);
        add("partial",     0, 1, 0, 0, 0, 8'hFF,  8'h00, 8'h00, 0, 2'b01);
        add("reset_mid",   1, 1, 0, 0, 0, 8'hFF,  8'h00, 8'h00, 0, 2'b00);
        add("rel2_e1",     0, 1, 0, 0, 0, 8'hFF,  8'h00, 8'h00, 0, 2'b01);
        add("rel2_step",   0, 1, 0, 0, 0, 8'hFF,  8'h01, 8'h00, 1, 2'b01);

        #2;
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].en, tbl[i].load, tbl[i].ud, tbl[i].cks, tbl[i].tdr);
            step_check(tbl[i].name, tbl[i].e_val, tbl[i].e_last, tbl[i].e_tick, tbl[i].e_state);
        end

        // Down wrap with divide-by-16 from 0x01.
        drive(1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 8'h01);
        step_check("dn_load", 8'h01, 8'h01, 1'b0, 2'b10);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 8'h01);
        for (int i = 1; i <= 33; i++) begin
            logic [7:0] ev;
            logic [7:0] el;
            ev = (i >= 32) ? 8'hFF : (i >= 16) ? 8'h00 : 8'h01;
            el = (i >= 33) ? 8'hFF : (i >= 17) ? 8'h00 : 8'h01;
            step_check($sformatf("dn_wrap_%0d", i), ev, el, (i == 16 || i == 32), 2'b01);
        end

        // Halt after 5 prescale counts: progress is lost on re-enable.
        drive(1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 8'h10);
        step_check("halt_load", 8'h10, 8'h10, 1'b0, 2'b10);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 8'h10);
        for (int i = 1; i <= 5; i++) begin
            step_check($sformatf("halt_run_%0d", i), 8'h10, 8'h10, 1'b0, 2'b01);
        end
        en = 1'b0;
        step_check("halt_idle", 8'h10, 8'h10, 1'b0, 2'b00);
        en = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            if (i < 16) begin
                step_check($sformatf("resume_%0d", i), 8'h10, 8'h10, 1'b0, 2'b01);
            end else begin
                step_check("resume_step", 8'h11, 8'h10, 1'b1, 2'b01);
            end
        end

        // Clock-select change 3 -> 0 at prescale count 10.
        for (int i = 1; i <= 10; i++) begin
            step_check($sformatf("cks3_%0d", i), 8'h11, 8'h11, 1'b0, 2'b01);
        end
        cks = 2'd0;
        step_check("cks_seen", 8'h11, 8'h11, 1'b0, 2'b01);
        step_check("cks_e1", 8'h11, 8'h11, 1'b0, 2'b01);
        step_check("cks_step", 8'h12, 8'h11, 1'b1, 2'b01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, miscompares);
        $finish;
    end

endmodule

// File: doc/timer_ctrl.md
# timer_ctrl

Sequencing controller for the 8-bit timer counter. Decodes the TCR control fields (enable, load, up/down, clock select) and applies the TDR load value. Runs a prescaler and steps the counter on prescaler terminal count. Drives the counter value and last-value pair consumed by the overflow/underflow checker; last-value is managed so the checker never sees a false wrap on a load.

## Interface
- CNT_WIDTH, 8, counter width; fixed at 8 to match the flow checker.
- tmrctl_clk  input  1  timer clock; all state updates on rising edge.
- tmrctl_reset  input  1  synchronous, active-high reset.
- tmrctl_tcr_en  input  1  count enable (1 = run).
- tmrctl_tcr_load  input  1  load request (level); counter forced to TDR while high.
- tmrctl_tcr_up_down  input  1  count direction: 0 = up, 1 = down.
- tmrctl_tcr_cks  input  2  prescale select: divide by 2^(cks+1), giving 2/4/8/16.
- tmrctl_tdr  input  8  load value.
- tmrctl_counter_value  output  8  current counter value (registered).
- tmrctl_counter_last_value  output  8  counter value of the previous cycle (registered).
- tmrctl_tick  output  1  one-cycle pulse, high in the cycle the counter shows a newly stepped value.
- tmrctl_state  output  2  FSM state: IDLE = 2'b00, RUN = 2'b01, LOAD = 2'b10.

## Operation
**Priority and state selection**
- Priority per cycle: reset > load > enable.
- Next state:
  - LOAD if tcr_load = 1.
  - else RUN if tcr_en = 1.
  - else IDLE.
- Evaluated every cycle from the current inputs, so any state can move to any state.

**IDLE**
- Counter holds its value.
- last_value <= counter_value.
- Prescaler cleared to 0.
- tick = 0.

**LOAD**
- Counter <= tdr.
- last_value <= tdr in the same edge. This guarantees last_value == value on the first cycle after load releases, so no false ovf/udf.
- Prescaler cleared.
- tick = 0.

**RUN**
- 4-bit prescaler pre_cnt increments every cycle.
- Terminal count = (2 << cks) - 1, i.e. 1, 3, 7 or 15.
- On terminal:
  - pre_cnt <= 0.
  - Counter steps +1 if up_down = 0, -1 if up_down = 1, modulo 256 (FF+1 = 00, 00-1 = FF).
  - tick <= 1.
- last_value <= counter_value every RUN cycle. The pair (FF→00 or 00→FF) is therefore visible for exactly one cycle after a wrap.

**Mid-run changes**
- cks change while in RUN: pre_cnt is cleared on the cycle the change is seen. The next step occurs a full new period later.
- up_down change while in RUN: affects the next step only. No immediate counter change, prescaler is not cleared.

**Re-entry and reset**
- RUN entry from IDLE or LOAD starts with pre_cnt = 0.
- Reset mid-count: all state is discarded, including a partial prescale.

## Timing
- Reset values (the cycle after reset is sampled high):
  - counter_value = 00, last_value = 00.
  - pre_cnt = 0, state = IDLE, tick = 0.
- Reset is held for as long as it is high and overrides load and enable.
- Load latency:
  - Load sampled at edge N gives counter_value = last_value = tdr after edge N.
  - A 1-cycle load pulse is sufficient.
- Step period in steady RUN: 2^(cks+1) cycles.
- First step after RUN entry:
  - Occurs at the 2^(cks+1)-th RUN edge.
  - tick is high during the following cycle, aligned with the new counter_value.
- Wrap visibility:
  - On the cycle after the step edge: last_value = old value, counter_value = new value.
  - One cycle later: last_value = new value.
- Enable dropped before terminal count: no step occurs and the prescale progress is lost.
- load and en both high: LOAD wins; counting resumes a full period after load drops.

## Test plan
- **Reset:** reset = 1 for 3 cycles with en = 1, load = 0, tdr = 0x55 -> value = 00, last = 00, tick = 0, state = 00 throughout; first step 2 cycles after release with cks = 0.
- **Load pulse:** tdr = 0xFE, 1-cycle load -> next cycle value = FE, last = FE, state = 10; following cycle state = IDLE, value still FE.
- **Up wrap, cks = 0:** from FE, en = 1, up_down = 0 -> value = FF after 2 cycles, value = 00 after 4 cycles; exactly one cycle with last = FF, value = 00; tick pulses once every 2 cycles.
- **Down wrap, cks = 3:** load 0x01, then run with up_down = 1 -> value = 00 after 16 cycles, value = FF after 32 cycles; exactly one cycle with last = 00, value = FF; ticks 16 cycles apart.
- **Halt and resume:**
  - Setup: cks = 3, drop en when pre_cnt = 5.
  - Expect: value holds, state = IDLE.
  - After re-enable: the next step takes a full 16 cycles.
- **Mid-run changes:**
  - Change cks 3→0 at pre_cnt = 10: next step 2 cycles after the change is seen.
  - Assert load with en = 1 at value 0x80, tdr = 0xFF: value = last = FF, no tick; resumes counting 2^(cks+1) cycles after load drops.
